// File: rtl/mpsoc_wb_pkg.sv
// Shared Wishbone B3 constants and the burst master state encoding.
package mpsoc_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {IDLE, WDATA, BUS, GAP} state_t;

endpackage

// File: rtl/mpsoc_wb_watchdog.sv
// Counts cycles while enabled; expired flags the last allowed cycle.
// TIMEOUT of 0 disables the watchdog entirely.
module mpsoc_wb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expired = (TIMEOUT != 0) && enable && (count == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mpsoc_wb_burst_master.sv
// Wishbone B3 initiator: one command at a time, classic or incrementing
// bursts, aborting on slave error, retry limit or ack timeout.
module mpsoc_wb_burst_master
  import mpsoc_wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LW      = 8,
  parameter int TIMEOUT = 1024,
  parameter int MAX_RTY = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic            wdat_valid_i,
  output logic            wdat_ready_o,
  input  logic [DW-1:0]   wdat_i,
  input  logic [DW/8-1:0] wsel_i,
  output logic            rdat_valid_o,
  output logic [DW-1:0]   rdat_o,
  output logic            rdat_last_o,
  output logic            done_o,
  output logic            err_o,
  output logic            busy_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam int RW = $clog2(MAX_RTY + 2);
  localparam logic [AW-1:0] STRIDE = AW'(DW / 8);

  state_t state, state_next;

  logic [LW-1:0] remain;
  logic          burst;
  logic [RW-1:0] rty_cnt;
  logic          expired, wd_clear;
  logic          last, ack_ok, rty_ok, abort;
  logic          ld_cmd, ld_wdat, adv, rty_inc, rd_cap, done_set, err_set;

  // err beats rty beats ack; an ack in the expiry cycle still counts
  assign last   = (remain == '0);
  assign ack_ok = wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign rty_ok = wb_rty_i & ~wb_err_i;
  assign abort  = wb_err_i | (expired & ~wb_ack_i & ~wb_rty_i) |
                  (rty_ok & (rty_cnt >= RW'(MAX_RTY)));

  assign busy_o   = (state != IDLE);
  assign wb_bte_o = BTE_LINEAR;
  assign wb_cti_o = !burst ? CTI_CLASSIC : (last ? CTI_EOB : CTI_INCR);
  assign wd_clear = ~wb_stb_o | wb_ack_i | wb_err_i | wb_rty_i;

  mpsoc_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (wd_clear),
    .enable  (wb_stb_o),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next   = state;
    ld_cmd       = 1'b0;
    ld_wdat      = 1'b0;
    adv          = 1'b0;
    rty_inc      = 1'b0;
    rd_cap       = 1'b0;
    done_set     = 1'b0;
    err_set      = 1'b0;
    cmd_ready_o  = 1'b0;
    wdat_ready_o = 1'b0;
    wb_cyc_o     = 1'b0;
    wb_stb_o     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          ld_cmd     = 1'b1;
          state_next = cmd_we_i ? WDATA : BUS;
        end
      end
      WDATA: begin
        wb_cyc_o     = 1'b1;
        wdat_ready_o = 1'b1;
        if (wdat_valid_i) begin
          ld_wdat    = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        if (abort) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end else if (rty_ok) begin
          rty_inc    = 1'b1;
          state_next = GAP;
        end else if (ack_ok) begin
          rd_cap = ~wb_we_o;
          if (last) begin
            done_set   = 1'b1;
            state_next = IDLE;
          end else begin
            adv = 1'b1;
            // next write beat streams straight in when the client has it
            if (wb_we_o) begin
              wdat_ready_o = 1'b1;
              if (wdat_valid_i) ld_wdat = 1'b1;
              else              state_next = WDATA;
            end
          end
        end
      end
      GAP: begin
        wb_cyc_o   = 1'b1;
        state_next = BUS;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      remain       <= '0;
      burst        <= 1'b0;
      rty_cnt      <= '0;
      rdat_valid_o <= 1'b0;
      rdat_o       <= '0;
      rdat_last_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      done_o       <= done_set;
      err_o        <= err_set;
      rdat_valid_o <= rd_cap;
      if (rd_cap) begin
        rdat_o      <= wb_dat_i;
        rdat_last_o <= last;
      end
      if (ld_cmd) begin
        wb_we_o  <= cmd_we_i;
        wb_adr_o <= cmd_adr_i;
        remain   <= cmd_len_i;
        burst    <= (cmd_len_i != '0);
        rty_cnt  <= '0;
        if (!cmd_we_i) wb_sel_o <= '1;
      end
      if (ld_wdat) begin
        wb_dat_o <= wdat_i;
        wb_sel_o <= wsel_i;
      end
      if (adv) begin
        wb_adr_o <= wb_adr_o + STRIDE;
        remain   <= remain - LW'(1);
        rty_cnt  <= '0;
      end
      if (rty_inc) rty_cnt <= rty_cnt + RW'(1);
    end
  end

endmodule

// File: tb/tb_mpsoc_wb_burst_master.sv
// Randomized scoreboard bench for mpsoc_wb_burst_master: a memory slave model
// answers the bus while a word-level reference memory predicts every beat.
module tb_mpsoc_wb_burst_master;

  localparam int AW = 32, DW = 32, LW = 8, TIMEOUT = 16, MAX_RTY = 4;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_ni = 1'b1;
  logic            cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [AW-1:0]   cmd_adr_i = '0;
  logic [LW-1:0]   cmd_len_i = '0;
  logic            wdat_valid_i = 1'b0, wdat_ready_o;
  logic [DW-1:0]   wdat_i = '0;
  logic [DW/8-1:0] wsel_i = '0;
  logic            rdat_valid_o, rdat_last_o, done_o, err_o, busy_o;
  logic [DW-1:0]   rdat_o, wb_dat_o;
  logic [DW-1:0]   wb_dat_i = '0;
  logic [AW-1:0]   wb_adr_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]      wb_cti_o;
  logic [1:0]      wb_bte_o;
  logic            wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  mpsoc_wb_burst_master #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TIMEOUT), .MAX_RTY(MAX_RTY)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i), .wsel_i(wsel_i),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .rdat_last_o(rdat_last_o),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  typedef struct packed {
    logic [31:0] adr; logic [2:0] cti; logic we; logic [31:0] dat; logic [3:0] sel; logic last;
  } beat_t;
  typedef struct packed { logic [31:0] dat; logic last; } rd_t;
  typedef struct packed { logic [31:0] dat; logic [3:0] sel; } wd_t;

  beat_t bus_q[$];
  rd_t   rd_q[$];
  bit    evt_q[$];
  wd_t   wdat_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] slv_mem [256];

  int checks = 0, failures = 0;
  int err_beat = -1, rty_left = 0, beat_cnt = 0, stall_left = 0;
  bit never_ack = 0, stalls_on = 0;
  int stb_cycles = 0, wait_cycles = 0, wait_at_watch = 0;
  logic [31:0] watch_adr = 32'hFFFF_FFFF;
  int hold_beat = -1, hold_cnt = 0, wdat_idx = 0;
  bit wfire = 0, term_prev = 0, rty_prev = 0;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: event occurred, none expected", name);
  endtask

  function automatic logic [2:0] cti_of(input int len, input int i);
    if (len == 0) return 3'b000;
    if (i == len) return 3'b111;
    return 3'b010;
  endfunction

  // Slave model, write-data client and bus-beat checker, all acting on the falling edge
  beat_t bexp;
  logic [7:0] sidx;
  always begin
    @(negedge wb_clk_i);
    if (!wb_rst_ni) begin
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wdat_valid_i = 0;
      wfire = 0; term_prev = 0; rty_prev = 0;
    end else begin
      if (wfire && wdat_q.size() > 0) begin
        void'(wdat_q.pop_front());
        wdat_idx++;
      end
      if (term_prev) checkOutput("cyc_drop_after_end", wb_cyc_o, 0);
      if (rty_prev)  checkOutput("stb_low_after_rty", wb_stb_o, 0);
      term_prev = 0; rty_prev = 0;
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      if (wb_cyc_o && !wb_stb_o) begin
        wait_cycles++;
        if (wb_adr_o == watch_adr) wait_at_watch++;
      end
      if (wb_cyc_o && wb_stb_o) begin
        stb_cycles++;
        if (never_ack) begin
        end else if (stall_left > 0) begin
          stall_left--;
        end else if (rty_left > 0) begin
          wb_rty_i = 1; rty_left--; rty_prev = 1;
        end else if (beat_cnt == err_beat) begin
          wb_err_i = 1; err_beat = -1; term_prev = 1;
        end else begin
          wb_ack_i = 1;
          sidx = wb_adr_o[9:2];
          if (wb_we_o) begin
            for (int b = 0; b < 4; b++)
              if (wb_sel_o[b]) slv_mem[sidx][8*b +: 8] = wb_dat_o[8*b +: 8];
          end else begin
            wb_dat_i = slv_mem[sidx];
          end
          beat_cnt++;
          stall_left = stalls_on ? int'($urandom_range(0, 2)) : 0;
        end
      end
      if (wdat_q.size() > 0 && !(wdat_idx == hold_beat && hold_cnt > 0)) begin
        wdat_valid_i = 1; wdat_i = wdat_q[0].dat; wsel_i = wdat_q[0].sel;
      end else begin
        wdat_valid_i = 0;
        if (wdat_idx == hold_beat && hold_cnt > 0 && wb_cyc_o && !wb_stb_o) hold_cnt--;
      end
      #1;
      wfire = wdat_valid_i & wdat_ready_o;
      if (wb_ack_i) begin
        if (bus_q.size() == 0) failNow("bus_beat_unexpected");
        else begin
          bexp = bus_q.pop_front();
          checkOutput("bus_beat adr/cti/we/dat/sel",
                      {wb_adr_o, wb_cti_o, wb_we_o, (wb_we_o ? wb_dat_o : 32'h0), wb_sel_o},
                      {bexp.adr, bexp.cti, bexp.we, bexp.dat, bexp.sel});
          if (bexp.last) term_prev = 1;
        end
      end
    end
  end

  // Scoreboard monitor for the client-side outputs
  rd_t rexp;
  bit  eexp;
  always begin
    @(negedge wb_clk_i);
    #2;
    if (wb_rst_ni) begin
      if (rdat_valid_o) begin
        if (rd_q.size() == 0) failNow("rdat_unexpected");
        else begin
          rexp = rd_q.pop_front();
          checkOutput("rdat data/last", {rdat_o, rdat_last_o}, {rexp.dat, rexp.last});
        end
      end
      if (done_o || err_o) begin
        if (evt_q.size() == 0) failNow("completion_unexpected");
        else begin
          eexp = evt_q.pop_front();
          checkOutput("completion err/done", {err_o, done_o}, eexp ? 2'b10 : 2'b01);
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] adr, input int len,
                               input int dmode, input logic [31:0] base, input int err_at,
                               input int rty_n, input bit no_ack, input bit rst_mid);
    int n_ok, budget;
    bit aborts;
    logic [31:0] a, d;
    logic [3:0] s;
    beat_t bt;
    aborts = (err_at >= 0) || (rty_n > MAX_RTY) || no_ack;
    n_ok = (no_ack || rty_n > MAX_RTY) ? 0 : ((err_at >= 0) ? err_at : len + 1);
    for (int i = 0; i <= len; i++) begin
      a = adr + 32'(4 * i);
      d = (dmode == 1) ? base + 32'(i) : $urandom;
      s = (dmode == 1) ? 4'hF : 4'($urandom_range(1, 15));
      if (we) wdat_q.push_back({d, s});
      if (i < n_ok) begin
        bt.adr = a; bt.cti = cti_of(len, i); bt.we = we;
        bt.dat = we ? d : 32'h0; bt.sel = we ? s : 4'hF; bt.last = (i == len);
        bus_q.push_back(bt);
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        end else begin
          rd_q.push_back({ref_mem[a[9:2]], 1'(i == len)});
        end
      end
    end
    if (!rst_mid) evt_q.push_back(aborts);
    err_beat = err_at; rty_left = rty_n; never_ack = no_ack; beat_cnt = 0; stall_left = 0;
    stb_cycles = 0; wait_cycles = 0; wait_at_watch = 0; wdat_idx = 0;
    @(negedge wb_clk_i);
    cmd_valid_i = 1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = LW'(len);
    #1 checkOutput("cmd_ready_before_cmd", cmd_ready_o, 1);
    @(negedge wb_clk_i);
    cmd_valid_i = 0;
    if (rst_mid) begin
      budget = 0;
      while (beat_cnt < 1 && budget < 100) begin @(negedge wb_clk_i); budget++; end
      if (beat_cnt < 1) failNow("first_beat_wait_expired");
      @(negedge wb_clk_i);
      #3 wb_rst_ni = 0;
      #1 checkOutput("reset_mid_burst cyc/stb/busy/cmd_ready",
                     {wb_cyc_o, wb_stb_o, busy_o, cmd_ready_o}, 4'b0001);
      bus_q.delete(); rd_q.delete(); evt_q.delete(); wdat_q.delete();
      repeat (3) @(negedge wb_clk_i);
      wb_rst_ni = 1;
      return;
    end
    budget = 0;
    while (busy_o && budget < 400) begin @(negedge wb_clk_i); budget++; end
    if (busy_o) failNow("completion_wait_expired");
    repeat (2) @(negedge wb_clk_i);
    checkOutput("queues_drained bus/rd/evt",
                {16'(bus_q.size()), 16'(rd_q.size()), 16'(evt_q.size())}, 48'h0);
    checkOutput("cmd_ready_after_cmd", cmd_ready_o, 1);
    wdat_q.delete();
    hold_beat = -1; hold_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
    #2 wb_rst_ni = 0;
    #1 checkOutput("reset_state outputs",
                   {cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o, rdat_last_o, done_o, err_o,
                    busy_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
                    wb_cti_o, wb_bte_o}, {1'b1, 114'b0});
    repeat (3) @(negedge wb_clk_i);
    wb_rst_ni = 1;

    $display("[TB] single classic write then read");
    applyStimulus(1, 32'h10, 0, 1, 32'hDEADBEEF, -1, 0, 0, 0);
    applyStimulus(0, 32'h10, 0, 1, 32'h0, -1, 0, 0, 0);

    $display("[TB] back-to-back burst write and readback");
    applyStimulus(1, 32'h100, 3, 1, 32'h1, -1, 0, 0, 0);
    checkOutput("burst_write_stb_gaps", wait_cycles, 1);
    applyStimulus(0, 32'h100, 3, 1, 32'h0, -1, 0, 0, 0);

    $display("[TB] write burst with client stall before beat 3");
    hold_beat = 2; hold_cnt = 5; watch_adr = 32'h208;
    applyStimulus(1, 32'h200, 3, 1, 32'h50, -1, 0, 0, 0);
    checkOutput("stall_cycles_at_third_beat", wait_at_watch, 6);
    watch_adr = 32'hFFFF_FFFF;
    applyStimulus(0, 32'h200, 3, 1, 32'h0, -1, 0, 0, 0);

    $display("[TB] slave error on beat 2 of 8-beat read");
    applyStimulus(0, 32'h100, 7, 1, 32'h0, 1, 0, 0, 0);

    $display("[TB] ack timeout and retry handling");
    applyStimulus(0, 32'h20, 0, 1, 32'h0, -1, 0, 1, 0);
    checkOutput("timeout_stb_cycles", stb_cycles, TIMEOUT);
    never_ack = 0;
    applyStimulus(0, 32'h40, 0, 1, 32'h0, -1, MAX_RTY + 1, 0, 0);
    applyStimulus(0, 32'h10, 0, 1, 32'h0, -1, 2, 0, 0);

    $display("[TB] reset during burst, then read at top of range");
    applyStimulus(0, 32'h100, 7, 1, 32'h0, -1, 0, 0, 1);
    applyStimulus(0, 32'h3FC, 0, 1, 32'h0, -1, 0, 0, 0);

    $display("[TB] randomized traffic");
    stalls_on = 1;
    for (int n = 0; n < 24; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), {22'h0, 8'($urandom_range(0, 255)), 2'b00},
                    int'($urandom_range(0, 7)), 0, 32'h0, -1, int'($urandom_range(0, 2)), 0, 0);
    end
    stalls_on = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit: simulation still running");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/mpsoc_wb_burst_master.md
Name: mpsoc_wb_burst_master

Overview:
Wishbone B3 initiator that turns simple command/stream requests into classic or incrementing-burst bus cycles toward memory slaves such as mpsoc_wb_spram. It is the synthesizable counterpart of the bench transactor, for use by DMA-style clients inside the MPSoC. It accepts one command at a time, streams write data in and read data out, and aborts the cycle on slave error, retry limit or ack timeout.

Parameters:
AW, 32, Wishbone address width (byte address)
DW, 32, data width; a multiple of 8
LW, 8, width of the command length field; bursts are 1..2^LW beats
TIMEOUT, 1024, maximum cycles with stb high and no ack/err/rty before abort; 0 disables the timeout
MAX_RTY, 4, retries allowed per beat before abort

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
cmd_we_i  in  1  1 = write, 0 = read
cmd_adr_i  in  AW  start byte address, DW/8 aligned
cmd_len_i  in  LW  beats minus 1
wdat_valid_i  in  1  write beat available
wdat_ready_o  out  1  write beat consumed
wdat_i  in  DW  write data
wsel_i  in  DW/8  write byte enables
rdat_valid_o  out  1  read beat valid, one-cycle pulse, no backpressure
rdat_o  out  DW  read data
rdat_last_o  out  1  final beat of the burst
done_o  out  1  one-cycle pulse on successful completion
err_o  out  1  one-cycle pulse on abort (err, retry limit or timeout)
busy_o  out  1  command in progress
wb_adr_o  out  AW  address
wb_dat_o  out  DW  write data
wb_sel_o  out  DW/8  byte select
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  cycle type identifier
wb_bte_o  out  2  burst type extension, constant 2'b00 (linear)
wb_dat_i  in  DW  read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error
wb_rty_i  in  1  retry

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except cmd_ready_o=1. Reset asserted mid-burst drops cyc and stb immediately.
- States:
  - IDLE: cmd_ready_o=1. On handshake, latch we, adr and remaining count = len. Next state is WDATA for a write, BUS for a read.
  - WDATA: cyc=1, stb=0, wdat_ready_o=1. On wdat handshake, load wb_dat_o and wb_sel_o, then go to BUS.
  - BUS: cyc=1, stb=1. Reads drive wb_sel_o to all ones.
  - GAP: one cycle with stb=0 after rty, then back to BUS with the same beat.
- First stb is asserted 1 cycle after the cmd handshake (read) or 1 cycle after the wdat handshake (write).
- CTI: len=0 gives 3'b000 (classic). Burst beats give 3'b010, and the final beat gives 3'b111.
- On ack for a non-final beat: wb_adr_o += DW/8, wrapping modulo 2^AW; the remaining count decrements.
  - Write: wdat_ready_o = wb_ack_i & ~last, a combinational path. If a beat is available it loads and stb stays high; otherwise go to WDATA with stb low and cyc held.
  - Read: stb stays high.
- On ack of the final beat: cyc and stb drop next cycle, done_o pulses, return to IDLE.
- Read data: rdat_valid_o, rdat_o and rdat_last_o are registered 1 cycle after each ack.
- wb_err_i, or a timeout: cyc and stb drop next cycle, err_o pulses, return to IDLE. Unsent write beats are not consumed; the client flushes them.
- wb_rty_i: go to GAP and increment the retry counter. When the counter exceeds MAX_RTY, abort as for err. The counter resets on each ack.
- Timeout counter resets on ack, err, rty and when stb is low. Abort when it reaches TIMEOUT with stb high.
- busy_o = (state != IDLE). ack, err and rty asserted together: err has priority, then rty.

Decomposition:
- Package mpsoc_wb_pkg holds:
  - constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111, BTE_LINEAR=2'b00;
  - state enum {IDLE, WDATA, BUS, GAP}.
- One sub-module, mpsoc_wb_watchdog: parameterized TIMEOUT counter with clear/enable inputs and an expired output.

Test Plan:
1. Write adr=0x10 len=0, data 0xDEADBEEF sel=4'hF, then read the same address -> cti=000 on both. done_o pulses twice. rdat_o=0xDEADBEEF with rdat_last_o=1.
2. Write burst adr=0x100 len=3 data 1,2,3,4 back-to-back, then read it back -> cti 010,010,010,111. Addresses 0x100, 0x104, 0x108, 0x10C. The write shows no stb gaps. Read returns 1,2,3,4 with last on the 4th beat.
3. Write len=3 with wdat_valid_i low for 5 cycles before beat 3 -> stb=0 and cyc=1 for those cycles, adr holds 0x108, readback is correct.
4. Read len=7 with slave err on beat 2 -> exactly one rdat_valid_o pulse, cyc=0 the next cycle, err_o pulse, cmd_ready_o=1.
5. TIMEOUT=16, slave never acks -> stb high 16 cycles, then cyc=0 and err_o pulse. rty asserted 5 times with MAX_RTY=4 -> err_o pulse; rty asserted twice -> beat reissued at the same address and done_o.
6. Assert wb_rst_ni during beat 2 of an 8-beat burst -> cyc, stb and busy_o fall to 0 immediately. After release, a single read at adr=0x3FC (top of a 1024-byte range) completes with done_o.
